// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-RAM responder: bus words, FSM states, address helper.
package dmem_responder_pkg;

    typedef logic [31:0] MemBus;
    typedef logic [31:0] MemAddrBus;

    localparam MemBus ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        DM_CLEAR = 2'd0,
        DM_RUN   = 2'd1,
        DM_DRAIN = 2'd2
    } DmemState;

    // Byte offset from the array base; bit 32 set means the address lies below base.
    function automatic logic [32:0] word_off(input MemAddrBus addr, input MemAddrBus base);
        return {1'b0, addr} - {1'b0, base};
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data memory port: combinational read, full-word write.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    MemAddrBus raddr;
    MemAddrBus waddr;
    logic      we;
    MemBus     wdata;
    MemBus     rdata;

    modport master (output raddr, output waddr, output we, output wdata, input rdata);
    modport slave  (input raddr, input waddr, input we, input wdata, output rdata);

endinterface

// File: rtl/dmem_wbuf.sv
// Single-entry write buffer; the held word is committed the cycle after capture.
module dmem_wbuf #(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      data,
    input  logic [IDX_W-1:0] ridx,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [31:0]      data_o,
    output logic             fwd_hit_o
);

    logic             vld_q, vld_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      data_q, data_d;

    // The entry drains every cycle, so validity simply follows the capture strobe.
    always_comb begin
        vld_d  = cap;
        idx_d  = idx_q;
        data_d = data_q;
        if (cap) begin
            idx_d  = idx;
            data_d = data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end

    assign vld_o     = vld_q;
    assign idx_o     = idx_q;
    assign data_o    = data_q;
    assign fwd_hit_o = vld_q && (idx_q == ridx);

endmodule

// File: rtl/dmem_responder.sv
// Data-RAM responder: zero-fill FSM, buffered writes with read forwarding.
// Optional DMEM_BOUNDS_CHK_EN: out-of-range accesses read zero, drop writes, pulse addr_err_o.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int        DEPTH     = 1024,
    parameter MemAddrBus BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req_i,
    dmem_responder_if.slave   bus,
    output logic              ready_o,
    output logic              addr_err_o
);

    localparam int IW = $clog2(DEPTH);

    DmemState        state_q, state_d;
    logic [IW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            clr_we;

    logic [32:0]     roff, woff;
    logic [IW-1:0]   ridx, widx;
    logic            rd_oob, wr_oob;
    logic            ready;
    logic            cap;

    logic            wbuf_vld, fwd_hit;
    logic [IW-1:0]   wbuf_idx;
    MemBus           wbuf_data;

    logic            arr_we;
    logic [IW-1:0]   arr_widx;
    MemBus           arr_wdata;
    MemBus           mem_q [DEPTH];
    MemBus           rdata;

    logic            unused_bits;

    assign roff = word_off(bus.raddr, BASE_ADDR);
    assign woff = word_off(bus.waddr, BASE_ADDR);
    assign ridx = roff[IW+1:2];
    assign widx = woff[IW+1:2];
    assign unused_bits = ^{roff, woff};

    assign ready   = (state_q == DM_RUN);
    assign ready_o = ready;

`ifdef DMEM_BOUNDS_CHK_EN
    localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH);

    logic addr_err_q, addr_err_d;

    assign rd_oob = roff[32] || (roff[31:0] >= SPAN_BYTES);
    assign wr_oob = woff[32] || (woff[31:0] >= SPAN_BYTES);

    always_comb begin
        addr_err_d = ready && (rd_oob || (bus.we && wr_oob));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) addr_err_q <= 1'b0;
        else        addr_err_q <= addr_err_d;
    end

    assign addr_err_o = addr_err_q;
`else
    assign rd_oob     = 1'b0;
    assign wr_oob     = 1'b0;
    assign addr_err_o = 1'b0;
`endif

    // Writes are only accepted in RUN; anything arriving while stalled is dropped.
    assign cap = ready && bus.we && !wr_oob;

    dmem_wbuf #(.IDX_W(IW)) u_wbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap       (cap),
        .idx       (widx),
        .data      (bus.wdata),
        .ridx      (ridx),
        .vld_o     (wbuf_vld),
        .idx_o     (wbuf_idx),
        .data_o    (wbuf_data),
        .fwd_hit_o (fwd_hit)
    );

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            DM_CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt_q == IW'(DEPTH - 1)) begin
                    state_d   = DM_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            DM_RUN: begin
                if (init_req_i) state_d = DM_DRAIN;
            end
            DM_DRAIN: begin
                state_d   = DM_CLEAR;
                clr_cnt_d = '0;
            end
            default: begin
                state_d   = DM_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DM_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // The buffer is never valid during CLEAR (capture only happens in RUN, DRAIN empties it).
    always_comb begin
        arr_we    = clr_we || wbuf_vld;
        arr_widx  = clr_we ? clr_cnt_q : wbuf_idx;
        arr_wdata = clr_we ? ZeroWord : wbuf_data;
    end

    always_ff @(posedge clk) begin
        if (arr_we) mem_q[arr_widx] <= arr_wdata;
    end

    always_comb begin
        rdata = ZeroWord;
        if (ready && !rd_oob) rdata = fwd_hit ? wbuf_data : mem_q[ridx];
    end

    assign bus.rdata = rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder (DEPTH=16) against a word-array model.
module tb_dmem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic init_req;
    logic ready_o;
    logic addr_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_req_i (init_req),
        .bus        (bus),
        .ready_o    (ready_o),
        .addr_err_o (addr_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit oob(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHK_EN
        longint unsigned x = longint'(a);
        return (x < longint'(BASE)) || (x >= longint'(BASE) + 4 * DEPTH);
`else
        return (a != a);
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off = a - BASE;
        return int'((off >> 2) % DEPTH);
    endfunction

    // Behavioural model: memory looks updated as soon as a write is accepted;
    // 'busy' counts the remaining stalled cycles.
    logic [31:0] mdl [DEPTH] = '{default: '0};
    int          busy  = DEPTH;
    bit          err_m = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit rdy;
        if (!rst_n) begin
            busy  = DEPTH;
            err_m = 1'b0;
            foreach (mdl[i]) mdl[i] = '0;
        end else begin
            rdy   = (busy == 0);
            err_m = rdy && (oob(bus.raddr) || (bus.we && oob(bus.waddr)));
            if (!rdy) busy--;
            else begin
                if (bus.we && !oob(bus.waddr)) mdl[widx(bus.waddr)] = bus.wdata;
                if (init_req) begin
                    busy = DEPTH + 1;
                    foreach (mdl[i]) mdl[i] = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] exp_rd;
        exp_rd = '0;
        if (busy == 0 && !oob(bus.raddr)) exp_rd = mdl[widx(bus.raddr)];
        chk("m_ready", {31'b0, ready_o}, {31'b0, busy == 0});
        chk("m_rdata", bus.rdata, exp_rd);
        chk("m_err", {31'b0, addr_err_o}, {31'b0, err_m});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        tick();
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string nm);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            bus.we = 1'b0; bus.raddr = 32'(i * 4);
            @(negedge clk);
            chk(nm, bus.rdata, 32'h0);
        end
    endtask

    initial begin
        int n;
        int pulses;
        rst_n = 1'b0; init_req = 1'b0;
        bus.we = 1'b0; bus.raddr = '0; bus.waddr = '0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, ready_o}, 32'h0);
        chk("rst_err", {31'b0, addr_err_o}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_ready(n);
        chk("rst_clear_len", 32'(n), 32'd16);
        check_all_zero("rst_zero");

        // forwarding, then array
        wr(32'h8, 32'hDEAD_BEEF); bus.raddr = 32'h8;
        @(negedge clk); chk("wr_same_cyc_old", bus.rdata, 32'h0);
        tick(); bus.we = 1'b0;
        @(negedge clk); chk("fwd_read", bus.rdata, 32'hDEAD_BEEF);
        tick(); tick();
        @(negedge clk); chk("array_read", bus.rdata, 32'hDEAD_BEEF);

        // back-to-back writes
        wr(32'h4, 32'h11); wr(32'h8, 32'h22); wr(32'h4, 32'h33);
        tick(); bus.we = 1'b0; bus.raddr = 32'h4;
        @(negedge clk); chk("b2b_0x4", bus.rdata, 32'h33);
        tick(); bus.raddr = 32'h8;
        @(negedge clk); chk("b2b_0x8", bus.rdata, 32'h22);

        // same-cycle write is invisible
        wr(32'hC, 32'h44); bus.raddr = 32'hC;
        @(negedge clk); chk("rmw_old", bus.rdata, 32'h0);
        tick(); bus.we = 1'b0;
        @(negedge clk); chk("rmw_new", bus.rdata, 32'h44);

        // 0x40: alias of word 0, or out of range
        wr(32'h0, 32'h77);
        tick(); bus.we = 1'b0; bus.raddr = 32'h40;
        @(negedge clk);
`ifdef DMEM_BOUNDS_CHK_EN
        chk("oob_rdata", bus.rdata, 32'h0);
        tick(); bus.raddr = 32'h0;
        @(negedge clk); chk("oob_err", {31'b0, addr_err_o}, 32'h1);
`else
        chk("alias_rdata", bus.rdata, 32'h77);
        tick(); bus.raddr = 32'h0;
        @(negedge clk); chk("alias_err", {31'b0, addr_err_o}, 32'h0);
`endif

        // init with the buffer holding a write; write during CLEAR is dropped
        wr(32'h14, 32'h99);
        tick(); bus.we = 1'b0; init_req = 1'b1;
        tick(); init_req = 1'b0;
        @(negedge clk); chk("drain_ready", {31'b0, ready_o}, 32'h0);
        tick(); bus.we = 1'b1; bus.waddr = 32'h20; bus.wdata = 32'h5555;
        tick(); bus.we = 1'b0;
        wait_ready(n);
        chk("clear_rest_len", 32'(n), 32'd15);
        check_all_zero("init_zero");

        // init held: ready pulses once per 18-cycle window
        tick(); init_req = 1'b1;
        pulses = 0;
        for (int k = 0; k < 54; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_o) pulses++;
        end
        init_req = 1'b0;
        chk("held_pulses", 32'(pulses), 32'd3);
        wait_ready(n);

        // reset mid-CLEAR, and reset with a pending buffer entry
        tick(); init_req = 1'b1;
        tick(); init_req = 1'b0;
        repeat (5) tick();
        #1 rst_n = 1'b0;
        @(negedge clk); chk("midclr_rst_ready", {31'b0, ready_o}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        wait_ready(n);
        chk("midclr_len", 32'(n), 32'd16);
        wr(32'h30, 32'hABC);
        tick(); bus.we = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        wait_ready(n);
        chk("rst_wbuf_len", 32'(n), 32'd16);
        tick(); bus.raddr = 32'h30;
        @(negedge clk); chk("rst_wbuf_drop", bus.rdata, 32'h0);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            tick();
            bus.we    = ($urandom_range(0, 2) != 0);
            bus.wdata = $urandom;
            bus.waddr = ($urandom_range(0, 15) == 0) ? 32'h40 + 32'($urandom_range(0, 63))
                                                     : 32'($urandom_range(0, 63));
            bus.raddr = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FF00 + 32'($urandom_range(0, 255))
                                                     : 32'($urandom_range(0, 63));
            init_req  = ($urandom_range(0, 79) == 0);
        end
        tick();
        bus.we = 1'b0; init_req = 1'b0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
